// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_T1   = 6;
    localparam int REG_A0   = 10;
    localparam int REG_A1   = 11;

    localparam int NDBG_DEF = 3;
    localparam int DBG_IDX_DEF [NDBG_DEF] = '{REG_A0, REG_A1, REG_T1};

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// One register's pending-write reservation counter. A reserve and a writeback
// in the same cycle cancel; overflow/underflow leave the count alone and pulse err.
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter int CW       = clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          full,
    output logic          err
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign full    = (cnt_q == CW'(MAX_PEND));
    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (inc && !dec) begin
            if (full) err = 1'b1;
            else      cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) err = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hardwired to zero, optional bypass or
// registered read, and per-register pending-write counters for hazard checks.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int RD_REG   = 0,
    parameter int BYPASS   = 1,
    parameter int MAX_PEND = 3,
    parameter int NDBG     = NDBG_DEF,
    parameter int DBG_IDX [NDBG] = DBG_IDX_DEF,
    localparam int AW      = clog2(NREGS),
    localparam int CW      = clog2(MAX_PEND + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_full,
    output logic                 err,
    output logic [NDBG*XLEN-1:0] dbg_data
);

    if ((1 << AW) != NREGS || NREGS < 2) begin : g_bad_nregs
        $error("regfile_sb: NREGS must be a power of 2 and >= 2");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_sb: NRD must be 1..4");
    end

    logic [XLEN-1:0]            regs_q [NREGS];
    logic [XLEN-1:0]            regs_d [NREGS];
    logic [NREGS-1:0][CW-1:0]   pend;
    logic [NREGS-1:0][CW-1:0]   pend_nxt;
    logic [NREGS-1:0]           full_v;
    logic [NREGS-1:0]           cerr_v;
    logic                       err_q, err_d;
    logic                       wr_hit, rsv_hit;

    // x0 never gets a counter, so its reservations and writebacks vanish here.
    assign wr_hit  = wr_en && (wr_addr != '0);
    assign rsv_hit = rsv_en && (rsv_addr != '0);

    assign pend[0]     = '0;
    assign pend_nxt[0] = '0;
    assign full_v[0]   = 1'b0;
    assign cerr_v[0]   = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        regfile_sb_cnt #(.MAX_PEND(MAX_PEND), .CW(CW)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (rsv_hit && (rsv_addr == AW'(r))),
            .dec     (wr_hit && (wr_addr == AW'(r))),
            .cnt     (pend[r]),
            .cnt_nxt (pend_nxt[r]),
            .full    (full_v[r]),
            .err     (cerr_v[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[wr_addr] = wr_data;
    end

    assign err_d    = err_q | (|cerr_v);
    assign err      = err_q;
    assign rsv_full = full_v[rsv_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];

        if (RD_REG == 0) begin : g_comb
            logic fwd;
            logic unused_nxt;
            assign unused_nxt = ^pend_nxt;
            assign fwd = (BYPASS != 0) && wr_hit && (wr_addr == a);
            assign rd_data[i*XLEN +: XLEN] = fwd ? wr_data : regs_q[a];
            // The last outstanding write is being forwarded, so nothing remains pending.
            assign rd_busy[i] = (pend[a] != '0) && !(fwd && (pend[a] == CW'(1)));
        end else begin : g_reg
            logic [XLEN-1:0] rdat_q, rdat_d;
            logic            busy_q, busy_d;
            logic            unused_cur;
            assign unused_cur = ^pend;
            assign rdat_d = regs_d[a];
            assign busy_d = (pend_nxt[a] != '0);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdat_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    rdat_q <= rdat_d;
                    busy_q <= busy_d;
                end
            end
            assign rd_data[i*XLEN +: XLEN] = rdat_q;
            assign rd_busy[i]              = busy_q;
        end
    end

    for (genvar k = 0; k < NDBG; k++) begin : g_dbg
        localparam logic [AW-1:0] IDX = AW'(DBG_IDX[k]);
        assign dbg_data[k*XLEN +: XLEN] = regs_q[IDX];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Random + directed scoreboard bench: comb/bypass, comb/no-bypass and registered
// instances share stimulus and are checked against an array-based model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XL = 32;
    localparam int AW = 5;
    localparam int MP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [2*AW-1:0] rd_addr = '0;
    logic            wr_en = 1'b0, rsv_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0, rsv_addr = '0;
    logic [XL-1:0]   wr_data = '0;

    logic [2*XL-1:0] rdc, rdn, rdr;
    logic [1:0]      bsc, bsn, bsr;
    logic            fc, fn, fr, ec, en, er;
    logic [3*XL-1:0] dgc, dgn, dgr;

    regfile_sb #(.RD_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdc), .rd_busy(bsc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_full(fc), .err(ec), .dbg_data(dgc));
    regfile_sb #(.RD_REG(0), .BYPASS(0)) u_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdn), .rd_busy(bsn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_full(fn), .err(en), .dbg_data(dgn));
    regfile_sb #(.RD_REG(1), .BYPASS(1)) u_r (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdr), .rd_busy(bsr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_full(fr), .err(er), .dbg_data(dgr));

    typedef struct {
        logic [1:0][31:0] dc, dn, dr;
        logic [1:0]       bc, bn, br;
        logic             full, err;
        logic [2:0][31:0] dbg;
    } exp_t;

    exp_t q[$];
    logic [1:0][31:0] prev_dr;
    logic [1:0]       prev_br;

    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_err   = 1'b0;
        prev_dr = '0;
        prev_br = '0;
    endfunction

    task automatic cyc(input bit we, input int wa, input logic [31:0] wd,
                       input bit re, input int ra, input int a0, input int a1);
        exp_t e;
        int   a;
        bit   inc, dec;
        @(posedge clk);
        #2;
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        rsv_en = re; rsv_addr = AW'(ra);
        rd_addr = {AW'(a1), AW'(a0)};
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? a0 : a1;
            e.dn[p] = m_regs[a];
            e.dc[p] = (we && wa == a && a != 0) ? wd : m_regs[a];
            e.bn[p] = (m_pend[a] != 0);
            e.bc[p] = (m_pend[a] != 0) && !(we && wa == a && m_pend[a] == 1);
        end
        e.dr   = prev_dr;
        e.br   = prev_br;
        e.full = (m_pend[ra] == MP);
        e.err  = m_err;
        e.dbg  = {m_regs[REG_T1], m_regs[REG_A1], m_regs[REG_A0]};
        q.push_back(e);
        inc = re && ra != 0;
        dec = we && wa != 0;
        if (dec) m_regs[wa] = wd;
        if (!(inc && dec && ra == wa)) begin
            if (inc) begin
                if (m_pend[ra] == MP) m_err = 1'b1;
                else                  m_pend[ra]++;
            end
            if (dec) begin
                if (m_pend[wa] == 0) m_err = 1'b1;
                else                 m_pend[wa]--;
            end
        end
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? a0 : a1;
            prev_dr[p] = m_regs[a];
            prev_br[p] = (m_pend[a] != 0);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        @(posedge clk);
        #2;
        wr_en = 1'b0; rsv_en = 1'b0; rd_addr = '0; wr_addr = '0; rsv_addr = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_r0", rdr[31:0], 32'h0);
        chk("rst_rd_r1", rdr[63:32], 32'h0);
        chk("rst_busy_r", {30'b0, bsr}, 32'h0);
        chk("rst_err", {29'b0, ec, en, er}, 32'h0);
        chk("rst_dbg_c_a0", dgc[31:0], 32'h0);
        chk("rst_dbg_r_t1", dgr[95:64], 32'h0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rd_c%0d", p), rdc[p*32 +: 32], e.dc[p]);
                    chk($sformatf("rd_n%0d", p), rdn[p*32 +: 32], e.dn[p]);
                    chk($sformatf("rd_r%0d", p), rdr[p*32 +: 32], e.dr[p]);
                    chk($sformatf("busy_c%0d", p), {31'b0, bsc[p]}, {31'b0, e.bc[p]});
                    chk($sformatf("busy_n%0d", p), {31'b0, bsn[p]}, {31'b0, e.bn[p]});
                    chk($sformatf("busy_r%0d", p), {31'b0, bsr[p]}, {31'b0, e.br[p]});
                end
                chk("full", {29'b0, fc, fn, fr}, {29'b0, e.full, e.full, e.full});
                chk("err", {29'b0, ec, en, er}, {29'b0, e.err, e.err, e.err});
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("dbg_c%0d", k), dgc[k*32 +: 32], e.dbg[k]);
                    chk($sformatf("dbg_r%0d", k), dgr[k*32 +: 32], e.dbg[k]);
                end
            end
        end
    end

    initial begin : stim
        int n;
        model_reset();
        do_reset();
        for (int k = 0; k < 32; k++) cyc(0, 0, 0, 0, 0, k, 31 - k);
        // x5 reserve, writeback, read back
        cyc(0, 0, 0, 1, 5, 0, 0);
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        cyc(0, 0, 0, 0, 0, 5, 5);
        // same-cycle write/read on x7: forwarded only with bypass
        cyc(0, 0, 0, 1, 7, 7, 0);
        cyc(1, 7, 32'h12345678, 0, 0, 7, 7);
        cyc(0, 0, 0, 0, 0, 7, 0);
        // x0 ignores writes and reservations
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // reserve+writeback same cycle on x4
        cyc(0, 0, 0, 1, 4, 4, 0);
        cyc(1, 4, 32'h00001111, 1, 4, 4, 4);
        cyc(0, 0, 0, 0, 0, 4, 4);
        cyc(1, 4, 32'h00002222, 0, 0, 4, 0);
        cyc(0, 0, 0, 0, 0, 4, 4);
        // underflow on x9
        cyc(1, 9, 32'h00000099, 0, 0, 9, 9);
        cyc(0, 0, 0, 0, 0, 9, 9);
        // leave a reservation outstanding, then reset mid-operation
        cyc(0, 0, 0, 1, 12, 12, 9);
        do_reset();
        cyc(0, 0, 0, 0, 0, 12, 9);
        // overflow on x3
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 3, 3, 0);
        cyc(0, 0, 0, 1, 3, 3, 3);
        cyc(0, 0, 0, 0, 0, 3, 3);
        for (int k = 0; k < 3; k++) cyc(1, 3, 32'h300 + k, 0, 3, 3, 3);
        cyc(0, 0, 0, 0, 0, 3, 3);
        // x10 shows on debug tap 0
        cyc(0, 0, 0, 1, 10, 0, 0);
        cyc(1, 10, 32'hA5A5A5A5, 0, 0, 10, 10);
        cyc(0, 0, 0, 0, 0, 10, 10);
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 11),
                $urandom_range(0, 11), $urandom_range(0, 11));
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
